// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------
// vga_pkg: shared cursor encoding, 640x480@60 timing, pipeline record
// Revision 1.0
// ---------------------------------------------------------------
`default_nettype none

package vga_pkg;

  typedef enum logic [1:0] {
    CUR_OFF   = 2'd0,
    CUR_BLOCK = 2'd1,
    CUR_BLINK = 2'd2,
    CUR_UNDER = 2'd3
  } cursor_mode_e;

  localparam int VGA640_H_ACTIVE = 640;
  localparam int VGA640_H_FP     = 16;
  localparam int VGA640_H_SYNC   = 96;
  localparam int VGA640_H_BP     = 48;
  localparam int VGA640_V_ACTIVE = 480;
  localparam int VGA640_V_FP     = 10;
  localparam int VGA640_V_SYNC   = 2;
  localparam int VGA640_V_BP     = 33;

  // Per-pixel terms that must stay in step with the returned colour
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic valid;
    logic hit;
  } vga_timing_t;

endpackage

`default_nettype wire

// File: rtl/vga_align_pipe.sv
// ---------------------------------------------------------------
// vga_align_pipe: DEPTH-stage delay line with a reset value
// Revision 1.0
// ---------------------------------------------------------------
`default_nettype none

module vga_align_pipe #(
  parameter int               DEPTH   = 1,
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             pclk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_bypass
      logic bypass_unused;
      assign bypass_unused = pclk ^ reset;
      assign dout = din;
    end else begin : g_shift
      logic [WIDTH-1:0] stage [DEPTH];

      always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
        end else begin
          stage[0] <= din;
          for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign dout = stage[DEPTH-1];
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/vga_text_timing.sv
// ---------------------------------------------------------------
// vga_text_timing: VGA raster timing with text-cell cursor overlay
// Revision 1.0
// ---------------------------------------------------------------
`default_nettype none

module vga_text_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE     = VGA640_H_ACTIVE,
  parameter int H_FP         = VGA640_H_FP,
  parameter int H_SYNC       = VGA640_H_SYNC,
  parameter int H_BP         = VGA640_H_BP,
  parameter int V_ACTIVE     = VGA640_V_ACTIVE,
  parameter int V_FP         = VGA640_V_FP,
  parameter int V_SYNC       = VGA640_V_SYNC,
  parameter int V_BP         = VGA640_V_BP,
  parameter bit SYNC_POL     = 1'b0,
  parameter int CELL_W       = 9,
  parameter int CELL_H       = 16,
  parameter int COLS         = 71,
  parameter int ROWS         = 30,
  parameter int ADDR_W       = 12,
  parameter int DATA_LAT     = 0,
  parameter int BLINK_FRAMES = 30,
  parameter int UL_ROWS      = 2
) (
  input  logic              pclk,
  input  logic              reset,
  input  logic [23:0]       vga_data,
  input  logic [ADDR_W-1:0] cursor_addr,
  input  logic [1:0]        cursor_mode,
  output logic [9:0]        h_addr,
  output logic [9:0]        v_addr,
  output logic              hsync,
  output logic              vsync,
  output logic              valid,
  output logic              frame_start,
  output logic [7:0]        vga_r,
  output logic [7:0]        vga_g,
  output logic [7:0]        vga_b
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int PX_W    = $clog2(CELL_W + 1);
  localparam int LN_W    = $clog2(CELL_H + 1);
  localparam int COL_W   = $clog2(COLS + 1);
  localparam int ROW_W   = $clog2(ROWS + 1);
  localparam int BF_W    = $clog2(BLINK_FRAMES + 1);

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic [PX_W-1:0]   PX_LAST   = PX_W'(CELL_W - 1);
  localparam logic [LN_W-1:0]   LN_LAST   = LN_W'(CELL_H - 1);
  localparam logic [LN_W-1:0]   UL_FIRST  = LN_W'(CELL_H - UL_ROWS);
  localparam logic [COL_W-1:0]  COL_END   = COL_W'(COLS);
  localparam logic [ROW_W-1:0]  ROW_END   = ROW_W'(ROWS);
  localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] NO_CURSOR = ADDR_W'(COLS * ROWS);
  localparam logic [BF_W-1:0]   BF_LAST   = BF_W'(BLINK_FRAMES);

  localparam vga_timing_t TERM_RST = '{hsync: ~SYNC_POL, vsync: ~SYNC_POL,
                                       valid: 1'b0, hit: 1'b0};

  logic [9:0]        h_cnt, v_cnt;
  logic [PX_W-1:0]   px;
  logic [LN_W-1:0]   ln;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [ADDR_W-1:0] row_base;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_eff, addr_smp, cell_idx;
  cursor_mode_e      cur_mode_q, cur_mode_eff;
  logic [BF_W-1:0]   blink_cnt;
  logic              phase_q, phase_eff, blink_wrap;
  logic              line_end, h_act, v_act, visible, fs_now, in_cell, on_cur;
  vga_timing_t       term_now, term_d;

  assign line_end = (h_cnt == H_LAST);
  assign h_act    = (h_cnt < H_ACT);
  assign v_act    = (v_cnt < V_ACT);
  assign visible  = h_act && v_act;
  assign fs_now   = (h_cnt == 10'd0) && (v_cnt == 10'd0);
  assign h_addr   = h_act ? h_cnt : 10'd0;
  assign v_addr   = v_act ? v_cnt : 10'd0;

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      h_cnt <= 10'd0;
      v_cnt <= 10'd0;
    end else if (line_end) begin
      h_cnt <= 10'd0;
      v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  // Cell position is tracked incrementally; col/row park at COLS/ROWS past the grid
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      px       <= '0;
      col      <= '0;
      ln       <= '0;
      row      <= '0;
      row_base <= '0;
    end else if (line_end) begin
      px  <= '0;
      col <= '0;
      if (v_cnt == V_LAST) begin
        ln       <= '0;
        row      <= '0;
        row_base <= '0;
      end else if (v_act && row != ROW_END) begin
        if (ln == LN_LAST) begin
          ln       <= '0;
          row      <= row + 1'b1;
          row_base <= row_base + COLS_A;
        end else begin
          ln <= ln + 1'b1;
        end
      end
    end else if (visible && col != COL_END) begin
      if (px == PX_LAST) begin
        px  <= '0;
        col <= col + 1'b1;
      end else begin
        px <= px + 1'b1;
      end
    end
  end

  // On the frame-start cycle the freshly sampled values already govern pixel (0,0)
  always_comb begin
    addr_smp     = (cursor_addr >= NO_CURSOR) ? NO_CURSOR : cursor_addr;
    blink_wrap   = (blink_cnt == BF_LAST);
    cur_addr_eff = fs_now ? addr_smp : cur_addr_q;
    cur_mode_eff = fs_now ? cursor_mode_e'(cursor_mode) : cur_mode_q;
    phase_eff    = (fs_now && blink_wrap) ? ~phase_q : phase_q;
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      cur_addr_q <= NO_CURSOR;
      cur_mode_q <= CUR_OFF;
      blink_cnt  <= '0;
      phase_q    <= 1'b1;
    end else if (fs_now) begin
      cur_addr_q <= addr_smp;
      cur_mode_q <= cursor_mode_e'(cursor_mode);
      if (blink_wrap) begin
        blink_cnt <= BF_W'(1);
        phase_q   <= ~phase_q;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    cell_idx       = row_base + ADDR_W'(col);
    in_cell        = visible && (col != COL_END) && (row != ROW_END);
    on_cur         = in_cell && (cell_idx == cur_addr_eff);
    term_now.hsync = (h_cnt >= HS_BEG && h_cnt < HS_END) ? SYNC_POL : ~SYNC_POL;
    term_now.vsync = (v_cnt >= VS_BEG && v_cnt < VS_END) ? SYNC_POL : ~SYNC_POL;
    term_now.valid = visible;
    term_now.hit   = 1'b0;
    case (cur_mode_eff)
      CUR_BLOCK: term_now.hit = on_cur;
      CUR_BLINK: term_now.hit = on_cur && phase_eff;
      CUR_UNDER: term_now.hit = on_cur && phase_eff && (ln >= UL_FIRST);
      default:   term_now.hit = 1'b0;
    endcase
  end

  vga_align_pipe #(
    .DEPTH   (DATA_LAT),
    .WIDTH   ($bits(vga_timing_t)),
    .RST_VAL (TERM_RST)
  ) u_align (
    .pclk  (pclk),
    .reset (reset),
    .din   (term_now),
    .dout  (term_d)
  );

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      hsync                 <= ~SYNC_POL;
      vsync                 <= ~SYNC_POL;
      valid                 <= 1'b0;
      frame_start           <= 1'b0;
      {vga_r, vga_g, vga_b} <= 24'd0;
    end else begin
      hsync       <= term_d.hsync;
      vsync       <= term_d.vsync;
      valid       <= term_d.valid;
      frame_start <= fs_now;
      if (!term_d.valid)   {vga_r, vga_g, vga_b} <= 24'd0;
      else if (term_d.hit) {vga_r, vga_g, vga_b} <= ~vga_data;
      else                 {vga_r, vga_g, vga_b} <= vga_data;
    end
  end

endmodule

`default_nettype wire

// File: doc/vga_text_timing.md
Name: vga_text_timing

Overview:
- Parametrised VGA raster timing generator with a text-cell cursor overlay, for the character-terminal display path.
- Generates counters, sync and blanking, and pixel coordinates for the upper-layer character renderer.
- Takes back 24-bit pixel colour after a configurable latency and aligns sync/valid with it.
- Overlays a block or underline cursor, steady or blinking, at a character-cell index. Blink rate is counted in frames.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch
- SYNC_POL, 0, sync active level (0 = active-low)
- CELL_W, 9, pixels per character column
- CELL_H, 16, lines per character row
- COLS, 71, character columns
- ROWS, 30, character rows
- ADDR_W, 12, cursor address width
- DATA_LAT, 0, pclk cycles from h_addr/v_addr to vga_data (0..3)
- BLINK_FRAMES, 30, frames per blink phase
- UL_ROWS, 2, underline height in lines

Ports:
- pclk  in  1  pixel clock
- reset  in  1  reset
- vga_data  in  24  pixel colour {r,g,b} for the coordinate issued DATA_LAT cycles earlier
- cursor_addr  in  ADDR_W  cursor cell index = row*COLS+col
- cursor_mode  in  2  0 off, 1 steady block, 2 blinking block, 3 blinking underline
- h_addr  out  10  current visible x, 0 when blanked
- v_addr  out  10  current visible y, 0 when blanked
- hsync  out  1  horizontal sync, aligned with colour
- vsync  out  1  vertical sync, aligned with colour
- valid  out  1  visible-pixel flag, aligned with colour
- frame_start  out  1  one-cycle pulse at h_cnt=0, v_cnt=0 (unaligned)
- vga_r, vga_g, vga_b  out  8 each  registered colour

Behaviour:
- Reset is asynchronous and active-high, on reset; clock pclk.
- Reset state:
  - All counters 0, blink phase 1 (cursor shown), latched cursor = COLS*ROWS (none).
  - Colour 0, valid 0, frame_start 0.
  - hsync/vsync at the inactive level (~SYNC_POL).
  - The delay pipeline is cleared to these same values.
- Counters (0-based):
  - h_cnt runs 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP.
  - v_cnt advances when h_cnt wraps and runs 0..V_TOTAL-1.
  - The first clock after reset release has h_cnt=0, v_cnt=0.
- Visible region: h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
  - h_addr = h_cnt and v_addr = v_cnt inside the region; each is 0 outside its own active range.
  - h_addr and v_addr are combinational from the counters.
- Sync windows:
  - hsync is active for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - vsync is active for the analogous v_cnt window, for whole lines.
- Cell tracking uses no division.
  - Registers: px (0..CELL_W-1) with col (0..COLS-1), and ln (0..CELL_H-1) with row (0..ROWS-1).
  - All four reset at the start of each line/frame and advance only inside the active region.
  - Pixels beyond COLS*CELL_W or lines beyond ROWS*CELL_H belong to no cell.
- Cursor latch: cursor_addr and cursor_mode are sampled on the frame_start cycle only.
  - Mid-frame changes take effect on the next frame.
  - A sampled cursor_addr >= COLS*ROWS means no cursor.
- Blink:
  - A frame counter counts frame_start pulses.
  - After BLINK_FRAMES pulses it clears and toggles the phase.
  - Phase 1 = cursor shown. Modes 0 and 1 ignore the phase.
- Cursor hit: (row*COLS+col) == latched address.
  - Mode 1: hit.
  - Mode 2: hit and phase 1.
  - Mode 3: hit, phase 1, and ln >= CELL_H-UL_ROWS.
- Alignment:
  - The hit, hsync, vsync and valid terms pass through a DATA_LAT-stage shift register.
  - They then pass one output register stage together with the colour.
  - Total output latency is DATA_LAT+1 cycles from the coordinate.
- Colour output:
  - Delayed valid=0: colour 0.
  - Delayed hit: bitwise ~vga_data.
  - Otherwise: vga_data.
- frame_start is registered from the counters and is not delayed.
- Reset asserted mid-frame returns everything to the reset state immediately. The next frame restarts at h_cnt=0.

Decomposition:
- Shared package vga_pkg:
  - Cursor mode encoding (CUR_OFF, CUR_BLOCK, CUR_BLINK, CUR_UNDER).
  - Timing constants for 640x480@60.
  - A timing record typedef.
- Natural sub-module: vga_align_pipe, a parametrised-depth/width delay line, reset to a given value.

Test Plan:
- Default params, release reset: hsync low for 96 cycles starting 657 cycles after release (656+1), period 800.
  - vsync low on lines 490-491, period 420000 cycles.
  - frame_start pulses at cycle 1 after release, then every 420000 cycles.
- vga_data = 24'h123456, mode 1, cursor_addr = 72:
  - Output 24'hEDCBA9 for x 9..17 and y 16..31 (one cycle later).
  - Output 24'h123456 for other visible pixels.
  - Output 0 in blanking.
- Mode 2, BLINK_FRAMES = 2, cursor_addr = 0:
  - Cursor inverted in frames 0-1, absent in frames 2-3, inverted in frames 4-5.
- Mode 3, UL_ROWS = 2, cursor_addr = 0: inversion only on y 14-15, x 0-8, during phase-1 frames.
- Change cursor_addr 0 -> 5 at line 100: the rest of the frame is still at cell 0, and the next frame is at cell 5 (x 45..53).
  - cursor_addr = 2130: no inversion anywhere.
  - x 639 (cell 71, outside COLS) never inverts.
- DATA_LAT = 2 with vga_data = h_addr delayed 2 cycles: colour equals x exactly where valid=1, with valid and hsync edges shifted 3 cycles.
  - Assert reset at line 200: outputs go to reset values at once, and the counters restart at 0 after release.
